bcd_chain_counter: RTL and testbench

Parametrised multi-digit BCD counter for the stopwatch/timer datapath, replacing the single fixed 0-99 counter. Each digit has its own compile-time maximum, so one instance can count mm:ss (digits 9,5,9,5) or plain decimal. Adds a run/stop FSM, up/down (stopwatch/countdown) mode, synchronous clear and parallel load, and carry/done flags. Sits between the 1 Hz tick generator and the seven-segment display driver.

---
 rtl/bcd_chain_counter.sv | 212 +++++++++++++++++++++
 tb/tb_bcd_chain_counter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_chain_counter.sv
// -----------------------------------------------------------------------------
// bcd_chain_counter
//
// Multi-digit BCD counter for the stopwatch/timer datapath. Each digit wraps
// at its own compile-time maximum (DIGIT_MAX), so one instance can count
// mm:ss (maxima 9,5,9,5 from digit 0 upwards) or plain decimal. A two-state
// run/stop FSM gates the 1 Hz tick. The counter counts up (stopwatch) or
// down (countdown), and supports synchronous clear and parallel load.
//
// Priority each cycle: clear > load > count.
//
// Optional feature, enabled by defining the macro BCD_CHAIN_LAP_EN:
//   A lap pulse freezes the displayed number while the internal count keeps
//   running. The next lap pulse releases the freeze. Clear, load and reset
//   also release it.
//
// Ports:
//   clock        in   system clock, all state changes on its rising edge
//   nRST         in   asynchronous active-low reset
//   second_tick  in   single-cycle count strobe
//   start_stop   in   single-cycle pulse, toggles run/stop
//   clear        in   synchronous clear to zero, forces STOP
//   load         in   synchronous parallel load, FSM state unaffected
//   load_value   in   BCD value for load; out-of-range digits are clamped
//   count_down   in   0 = count up, 1 = count down
//   number       out  current BCD count, digit 0 in the LSBs
//   running      out  high while the FSM is in RUN
//   carry_out    out  one-cycle pulse when an up-count wraps to zero
//   done         out  one-cycle pulse when a down-count reaches zero
//   lap          in   (BCD_CHAIN_LAP_EN only) toggles the display freeze
//   lap_active   out  (BCD_CHAIN_LAP_EN only) high while the display is frozen
// -----------------------------------------------------------------------------
module bcd_chain_counter #(
    parameter int                        NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0]   DIGIT_MAX  = {4'd5, 4'd9, 4'd5, 4'd9}
) (
    input  logic                      clock,
    input  logic                      nRST,
    input  logic                      second_tick,
    input  logic                      start_stop,
    input  logic                      clear,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    input  logic                      count_down,
`ifdef BCD_CHAIN_LAP_EN
    input  logic                      lap,
    output logic                      lap_active,
`endif
    output logic [4*NUM_DIGITS-1:0]   number,
    output logic                      running,
    output logic                      carry_out,
    output logic                      done
);

    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    count_q, count_d;
    logic            carry_q, carry_d;
    logic            done_q,  done_d;

    // Scratch values for the ripple computation; fully assigned every pass.
    logic [W-1:0]    stepped;
    logic            inc;
    logic            borrow;
    logic            count_is_zero;

    // Clamp every digit of a load value to that digit's maximum. This also
    // catches non-BCD nibbles 10..15, since every maximum is at most 9.
    function automatic logic [W-1:0] clamp_load(input logic [W-1:0] value);
        logic [W-1:0] result;
        result = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (value[4*i +: 4] > DIGIT_MAX[4*i +: 4]) begin
                result[4*i +: 4] = DIGIT_MAX[4*i +: 4];
            end
        end
        return result;
    endfunction

    assign count_is_zero = (count_q == '0);

    // -------------------------------------------------------------------------
    // Next-state logic: FSM, count chain and the single-cycle flags
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        carry_d = 1'b0;
        done_d  = 1'b0;
        stepped = count_q;
        inc     = 1'b1;
        borrow  = 1'b1;

        // Run/stop toggle. Starting a countdown from zero would only produce
        // an immediate underflow, so that start is refused.
        if (start_stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_STOP;
            end else if (!(count_down && count_is_zero)) begin
                state_d = ST_RUN;
            end
        end

        if (clear) begin
            count_d = '0;
            state_d = ST_STOP;
        end else if (load) begin
            count_d = clamp_load(load_value);
        end else if ((state_q == ST_RUN) && second_tick) begin
            // The tick is qualified by the pre-toggle state, so a start_stop
            // arriving with the tick never changes whether this tick counts.
            if (!count_down) begin
                // Ripple increment: a digit at its maximum rolls to zero and
                // passes the increment on to the next digit.
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (inc) begin
                        if (count_q[4*i +: 4] >= DIGIT_MAX[4*i +: 4]) begin
                            stepped[4*i +: 4] = 4'd0;
                        end else begin
                            stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                            inc               = 1'b0;
                        end
                    end
                end
                count_d = stepped;
                carry_d = inc;
            end else if (!count_is_zero) begin
                // Ripple decrement: a digit at zero becomes its maximum and
                // passes the borrow on. Holding at zero keeps the count from
                // ever going negative.
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (borrow) begin
                        if (count_q[4*i +: 4] == 4'd0) begin
                            stepped[4*i +: 4] = DIGIT_MAX[4*i +: 4];
                        end else begin
                            stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                            borrow            = 1'b0;
                        end
                    end
                end
                count_d = stepped;
                if (stepped == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_STOP;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_STOP;
            count_q <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign running   = (state_q == ST_RUN);
    assign carry_out = carry_q;
    assign done      = done_q;

`ifdef BCD_CHAIN_LAP_EN
    // -------------------------------------------------------------------------
    // Lap freeze: a separate display register follows the live count until
    // frozen. On the freezing edge it keeps its value, which equals the
    // pre-edge count because it was tracking until then.
    // -------------------------------------------------------------------------
    logic            lap_q, lap_d;
    logic [W-1:0]    disp_q, disp_d;

    always_comb begin
        lap_d = lap_q;
        if (clear || load) begin
            lap_d = 1'b0;
        end else if (lap) begin
            lap_d = ~lap_q;
        end
        disp_d = lap_d ? disp_q : count_d;
    end

    always_ff @(posedge clock or negedge nRST) begin
        if (!nRST) begin
            lap_q  <= 1'b0;
            disp_q <= '0;
        end else begin
            lap_q  <= lap_d;
            disp_q <= disp_d;
        end
    end

    assign number     = disp_q;
    assign lap_active = lap_q;
`else
    assign number = count_q;
`endif

endmodule

// File: tb/tb_bcd_chain_counter.sv
// -----------------------------------------------------------------------------
// Testbench for bcd_chain_counter (default mm:ss configuration).
// A driver applies one cycle of stimulus per call and pushes the expected
// post-edge outputs, computed by a mixed-radix integer model, into a queue.
// A monitor pops one entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_bcd_chain_counter;

    localparam int          ND   = 4;
    localparam int          W    = 4 * ND;
    localparam logic [W-1:0] DMAX = {4'd5, 4'd9, 4'd5, 4'd9};

    logic          clock;
    logic          nRST;
    logic          second_tick;
    logic          start_stop;
    logic          clear;
    logic          load;
    logic [W-1:0]  load_value;
    logic          count_down;
    logic          lap;
    logic [W-1:0]  number;
    logic          running;
    logic          carry_out;
    logic          done;
`ifdef BCD_CHAIN_LAP_EN
    logic          lap_active;
`endif

    bcd_chain_counter #(
        .NUM_DIGITS (ND),
        .DIGIT_MAX  (DMAX)
    ) dut (
        .clock       (clock),
        .nRST        (nRST),
        .second_tick (second_tick),
        .start_stop  (start_stop),
        .clear       (clear),
        .load        (load),
        .load_value  (load_value),
        .count_down  (count_down),
`ifdef BCD_CHAIN_LAP_EN
        .lap         (lap),
        .lap_active  (lap_active),
`endif
        .number      (number),
        .running     (running),
        .carry_out   (carry_out),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] num;
        logic         run;
        logic         cy;
        logic         dn;
        logic         lapa;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model state: the count as a plain integer.
    int            m_val;
    bit            m_run;
    bit            m_lap;
    int            m_frz;
    bit            cur_dn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int radix(input int i);
        logic [W-1:0] m;
        m = DMAX;
        return int'(m[4*i +: 4]) + 1;
    endfunction

    function automatic int total_states();
        int t = 1;
        for (int i = 0; i < ND; i++) t *= radix(i);
        return t;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] b);
        int v = 0;
        int w = 1;
        for (int i = 0; i < ND; i++) begin
            v += int'(b[4*i +: 4]) * w;
            w *= radix(i);
        end
        return v;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] b = '0;
        int r = v;
        for (int i = 0; i < ND; i++) begin
            b[4*i +: 4] = 4'(r % radix(i));
            r = r / radix(i);
        end
        return b;
    endfunction

    // Per-digit clamp, then convert to the integer count.
    function automatic int load_to_int(input logic [W-1:0] lv);
        logic [W-1:0] b = lv;
        for (int i = 0; i < ND; i++) begin
            if (int'(lv[4*i +: 4]) > radix(i) - 1) b[4*i +: 4] = 4'(radix(i) - 1);
        end
        return bcd_to_int(b);
    endfunction

    // One cycle of stimulus plus the model's prediction of the outputs after
    // the following rising edge.
    task automatic step(input bit ss, input bit tk, input bit cl, input bit ld,
                        input logic [W-1:0] lv, input bit lp);
        exp_t e;
        bit   new_run;
        bit   cy = 0;
        bit   dn = 0;
        @(negedge clock);
        start_stop  = ss;
        second_tick = tk;
        clear       = cl;
        load        = ld;
        load_value  = lv;
        count_down  = cur_dn;
        lap         = lp;

        if (cl) begin
            m_val = 0;
            m_run = 0;
            m_lap = 0;
        end else begin
            new_run = m_run;
            if (ss) begin
                if (m_run) new_run = 0;
                else if (!(cur_dn && m_val == 0)) new_run = 1;
            end
            if (ld) begin
                m_val = load_to_int(lv);
                m_lap = 0;
            end else begin
`ifdef BCD_CHAIN_LAP_EN
                if (lp) begin
                    if (!m_lap) m_frz = m_val;
                    m_lap = !m_lap;
                end
`endif
                if (m_run && tk) begin
                    if (!cur_dn) begin
                        m_val = m_val + 1;
                        if (m_val == total_states()) begin
                            m_val = 0;
                            cy    = 1;
                        end
                    end else if (m_val > 0) begin
                        m_val = m_val - 1;
                        if (m_val == 0) begin
                            dn      = 1;
                            new_run = 0;
                        end
                    end
                end
            end
            m_run = new_run;
        end
        e.num  = int_to_bcd(m_lap ? m_frz : m_val);
        e.run  = m_run;
        e.cy   = cy;
        e.dn   = dn;
        e.lapa = m_lap;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
    endtask

    // Monitor: one expected entry per rising edge while the driver is active.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("number",    32'(number),    32'(e.num));
                check("running",   32'(running),   32'(e.run));
                check("carry_out", 32'(carry_out), 32'(e.cy));
                check("done",      32'(done),      32'(e.dn));
`ifdef BCD_CHAIN_LAP_EN
                check("lap_active", 32'(lap_active), 32'(e.lapa));
`endif
            end
        end
    end

    initial begin
        int drain;
        nRST        = 1'b0;
        second_tick = 1'b0;
        start_stop  = 1'b0;
        clear       = 1'b0;
        load        = 1'b0;
        load_value  = '0;
        count_down  = 1'b0;
        lap         = 1'b0;
        m_val = 0; m_run = 0; m_lap = 0; m_frz = 0; cur_dn = 0;

        repeat (2) @(negedge clock);
        check("reset_number",  32'(number),    32'h0);
        check("reset_running", 32'(running),   32'h0);
        check("reset_carry",   32'(carry_out), 32'h0);
        check("reset_done",    32'(done),      32'h0);
        nRST = 1'b1;

        // Up count across the full wrap: 59:58 -> 59:59 -> 00:00 with carry.
        cur_dn = 0;
        step(0, 0, 0, 1, 16'h5958, 0);
        step(1, 0, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        idle(2);

        // Countdown to zero: done pulses, FSM stops, ticks and restart refused.
        cur_dn = 1;
        step(1, 0, 0, 0, '0, 0);
        step(0, 0, 0, 1, 16'h0001, 0);
        step(1, 0, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        idle(1);

        // Load clamping of digits above their maximum, including non-BCD.
        step(0, 0, 0, 1, 16'hF7A3, 0);
        idle(1);

        // Clear beats load and tick while running; then start with a tick.
        cur_dn = 0;
        step(1, 0, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        step(0, 1, 1, 1, 16'h1234, 0);
        step(1, 1, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        step(1, 1, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        step(0, 0, 1, 0, '0, 0);

`ifdef BCD_CHAIN_LAP_EN
        // Freeze at 12, count five more, release shows 17.
        step(0, 0, 0, 1, 16'h0012, 0);
        step(1, 0, 0, 0, '0, 0);
        step(0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, '0, 0);
        step(0, 0, 0, 0, '0, 1);
        step(1, 0, 0, 0, '0, 0);
        idle(1);
`endif

        // Asynchronous reset in the middle of a count at 03:42.
        step(0, 0, 0, 1, 16'h0340, 0);
        step(1, 0, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        step(0, 1, 0, 0, '0, 0);
        idle(1);
        check("pre_reset_number", 32'(number), 32'h0342);
        @(posedge clock);
        #2;
        nRST = 1'b0;
        #1;
        check("async_reset_number",  32'(number),  32'h0);
        check("async_reset_running", 32'(running), 32'h0);
        m_val = 0; m_run = 0; m_lap = 0;
        @(negedge clock);
        nRST = 1'b1;
        idle(1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit ss, tk, cl, ld, lp;
            logic [W-1:0] lv;
            if ($urandom_range(0, 29) == 0) cur_dn = !cur_dn;
            ss = ($urandom_range(0, 15) == 0);
            tk = ($urandom_range(0, 1) == 0);
            cl = ($urandom_range(0, 59) == 0);
            ld = ($urandom_range(0, 24) == 0);
            lp = ($urandom_range(0, 9) == 0);
            lv = W'($urandom);
            if (cur_dn && $urandom_range(0, 1) == 0) lv = W'($urandom_range(0, 3));
            step(ss, tk, cl, ld, lv, lp);
        end
        idle(2);

        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(negedge clock);
            drain++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
